// File: rtl/trig_gen_pkg.sv
// trig_burst_gen shared definitions: FSM encoding,
// clamp limits and default field width.
`timescale 1ns/1ps
package trig_gen_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int STEP_MIN  = 2;
  localparam int WIDTH_MIN = 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DELAY = 2'd1;
  localparam state_t ST_PULSE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/trig_in_sync.sv
// Multi-stage synchroniser; EDGE selects a rising-edge
// pulse output instead of the synchronised level.
`timescale 1ns/1ps
module trig_in_sync #(
  parameter int STAGES = 2,
  parameter bit EDGE   = 1'b0
) (
  input  logic I_clk_100mhz,
  input  logic I_Rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge I_clk_100mhz or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[STAGES-2:0], din};
      prev <= sr[STAGES-1];
    end
  end

  assign dout = EDGE ? (sr[STAGES-1] & ~prev)
                     : sr[STAGES-1];

endmodule

// File: rtl/trig_burst_gen.sv
// Multi-channel burst trigger generator.
// Define TRIG_GEN_CONT_EN to make Num==0 run continuously.
`timescale 1ns/1ps
module trig_burst_gen
  import trig_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             I_clk_100mhz,
  input  logic             I_Rst_n,
  input  logic             I_Trig_in,
  input  logic             I_Abort,
  input  logic [CNT_W-1:0] I_Trig_Num,
  input  logic [CNT_W-1:0] I_Trig_Step,
  input  logic [CNT_W-1:0] I_Trig_Width,
  input  logic [CNT_W-1:0] I_Trig_Delay,
  input  logic [N_CH-1:0]  I_Ch_En,
  output logic [N_CH-1:0]  O_Trig,
  output logic             O_Busy,
  output logic             O_Done,
  output logic [CNT_W-1:0] O_Pulse_Cnt
);

`ifdef TRIG_GEN_CONT_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] SMIN = CNT_W'(STEP_MIN);
  localparam logic [CNT_W-1:0] WMIN = CNT_W'(WIDTH_MIN);

  state_t state, state_nxt;

  logic             trig_rise;
  logic             abort_lvl;
  logic             start;
  logic [CNT_W-1:0] step_c, width_c;
  logic             cont_in;
  logic [CNT_W-1:0] num_q, step_q, width_q, delay_q;
  logic [N_CH-1:0]  en_q;
  logic             cont_q;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             period_end;
  logic             pulse_rise;
  logic [CNT_W-1:0] width_eff;
  logic [N_CH-1:0]  en_eff;
  logic [N_CH-1:0]  trig_d;
  logic             busy_d, done_d;
  logic [CNT_W-1:0] pcnt_d;

  trig_in_sync #(
    .STAGES (SYNC_STAGES),
    .EDGE   (1'b1)
  ) u_sync_trig (
    .I_clk_100mhz (I_clk_100mhz),
    .I_Rst_n      (I_Rst_n),
    .din          (I_Trig_in),
    .dout         (trig_rise)
  );

  trig_in_sync #(
    .STAGES (SYNC_STAGES),
    .EDGE   (1'b0)
  ) u_sync_abort (
    .I_clk_100mhz (I_clk_100mhz),
    .I_Rst_n      (I_Rst_n),
    .din          (I_Abort),
    .dout         (abort_lvl)
  );

  // abort level dominates a coincident start edge
  assign start = trig_rise & ~abort_lvl
               & (state == ST_IDLE);

  assign step_c = (I_Trig_Step < SMIN) ? SMIN
                                       : I_Trig_Step;

  assign width_c = (I_Trig_Width < WMIN) ? WMIN :
                   (I_Trig_Width >= step_c) ? step_c - ONE :
                   I_Trig_Width;

  assign cont_in = CONT_EN & (I_Trig_Num == '0);

  assign period_end = (cnt_q == step_q - ONE);

  always_ff @(posedge I_clk_100mhz or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      num_q   <= '0;
      step_q  <= SMIN;
      width_q <= WMIN;
      delay_q <= '0;
      en_q    <= '0;
      cont_q  <= 1'b0;
    end else if (start) begin
      num_q   <= I_Trig_Num;
      step_q  <= step_c;
      width_q <= width_c;
      delay_q <= I_Trig_Delay;
      en_q    <= I_Ch_En;
      cont_q  <= cont_in;
    end
  end

  always_ff @(posedge I_clk_100mhz or negedge I_Rst_n) begin
    if (!I_Rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if ((I_Trig_Num == '0) && !CONT_EN)
            state_nxt = ST_DONE;
          else if (I_Trig_Delay != '0)
            state_nxt = ST_DELAY;
          else
            state_nxt = ST_PULSE;
        end
      end
      ST_DELAY: begin
        if (abort_lvl)
          state_nxt = ST_DONE;
        else if (cnt_q == delay_q)
          state_nxt = ST_PULSE;
      end
      ST_PULSE: begin
        if (abort_lvl)
          state_nxt = ST_DONE;
        else if (period_end && !cont_q
                 && (O_Pulse_Cnt == num_q))
          state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // cnt_q counts delay cycles, then the phase within a period
  always_comb begin
    cnt_nxt = '0;
    unique case (1'b1)
      (state_nxt == ST_DELAY):
        cnt_nxt = (state == ST_IDLE) ? ONE
                                     : cnt_q + ONE;
      (state_nxt == ST_PULSE):
        cnt_nxt = (state == ST_PULSE && !period_end)
                ? cnt_q + ONE : '0;
      default: cnt_nxt = '0;
    endcase
  end

  always_comb begin
    pulse_rise = (state_nxt == ST_PULSE)
               && (cnt_nxt == '0);
    width_eff  = start ? width_c : width_q;
    en_eff     = start ? I_Ch_En : en_q;
    trig_d     = '0;
    if (state_nxt == ST_PULSE && cnt_nxt < width_eff)
      trig_d = en_eff;
    busy_d = (state_nxt != ST_IDLE);
    done_d = (state_nxt == ST_DONE);
    if (start)
      pcnt_d = pulse_rise ? ONE : '0;
    else if (pulse_rise)
      pcnt_d = O_Pulse_Cnt + ONE;
    else
      pcnt_d = O_Pulse_Cnt;
  end

  always_ff @(posedge I_clk_100mhz or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      cnt_q       <= '0;
      O_Trig      <= '0;
      O_Busy      <= 1'b0;
      O_Done      <= 1'b0;
      O_Pulse_Cnt <= '0;
    end else begin
      cnt_q       <= cnt_nxt;
      O_Trig      <= trig_d;
      O_Busy      <= busy_d;
      O_Done      <= done_d;
      O_Pulse_Cnt <= pcnt_d;
    end
  end

endmodule

// File: tb/tb_trig_burst_gen.sv
// Directed scoreboard bench for trig_burst_gen.
// Honours TRIG_GEN_CONT_EN for the Num==0 case.
`timescale 1ns/1ps
module tb_trig_burst_gen;

  localparam int CW = 32;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trig_in;
  logic          abort;
  logic [CW-1:0] t_num, t_step, t_width, t_delay;
  logic [NC-1:0] ch_en;
  logic [NC-1:0] o_trig;
  logic          o_busy, o_done;
  logic [CW-1:0] o_cnt;

  typedef struct packed {
    logic [NC-1:0] trig;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t          sb_q[$];
  obs_t          obs;
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [CW-1:0] last_cnt = '0;

  always #5 clk = ~clk;

  assign obs = {o_trig, o_busy, o_done, o_cnt};

  trig_burst_gen dut (
    .I_clk_100mhz (clk),
    .I_Rst_n      (rst_n),
    .I_Trig_in    (trig_in),
    .I_Abort      (abort),
    .I_Trig_Num   (t_num),
    .I_Trig_Step  (t_step),
    .I_Trig_Width (t_width),
    .I_Trig_Delay (t_delay),
    .I_Ch_En      (ch_en),
    .O_Trig       (o_trig),
    .O_Busy       (o_busy),
    .O_Done       (o_done),
    .O_Pulse_Cnt  (o_cnt)
  );

  task automatic check(string tag, obs_t got, obs_t exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got trig=%b busy=%b done=%b cnt=%0d, want trig=%b busy=%b done=%b cnt=%0d",
             tag, got.trig, got.busy, got.done, got.cnt,
             exp.trig, exp.busy, exp.done, exp.cnt);
    end
  endtask

  task automatic cfg(int num, int step, int width,
                     int dly, logic [NC-1:0] en);
    t_num   = CW'(num);
    t_step  = CW'(step);
    t_width = CW'(width);
    t_delay = CW'(dly);
    ch_en   = en;
  endtask

  // expected per-cycle outputs for cycles 1..ncyc after start
  task automatic push_burst(int num, int step, int width,
                            int dly, logic [NC-1:0] en,
                            int abort_c, int ncyc);
    longint sc, wc, fin, p, k, ph;
    logic [CW-1:0] cnt_h;
    obs_t e;
    bit cont;
    sc = (step < 2) ? 2 : step;
    wc = (width == 0) ? 1 : width;
    if (wc >= sc) wc = sc - 1;
    cont = 1'b0;
`ifdef TRIG_GEN_CONT_EN
    cont = (num == 0);
`endif
    if (cont)          fin = 64'h7fff_ffff_ffff;
    else if (num == 0) fin = 1;
    else               fin = dly + num * sc + 1;
    if (abort_c > 0 && abort_c + 2 < fin)
      fin = abort_c + 3;
    cnt_h = '0;
    for (int n = 1; n <= ncyc; n++) begin
      e = '0;
      if (n < fin) begin
        e.busy = 1'b1;
        if (n > dly) begin
          p  = n - dly - 1;
          k  = p / sc;
          ph = p % sc;
          e.cnt = CW'(k + 1);
          if (ph < wc) e.trig = en;
        end
        cnt_h = e.cnt;
      end else if (n == fin) begin
        e.busy = 1'b1;
        e.done = 1'b1;
        e.cnt  = cnt_h;
      end else begin
        e.cnt = cnt_h;
      end
      sb_q.push_back(e);
    end
    last_cnt = cnt_h;
  endtask

  task automatic push_idle(int ncyc);
    obs_t e;
    e = '0;
    e.cnt = last_cnt;
    for (int n = 1; n <= ncyc; n++) sb_q.push_back(e);
  endtask

  // called on a negedge; cycle n is sampled at negedge n+2
  task automatic run(string name, int ncyc, bit start,
                     int abort_c, int retrig_c, bit mutate);
    obs_t e;
    if (start) trig_in = 1'b1;
    repeat (2) @(negedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      check($sformatf("%s_c%0d", name, n), obs, e);
      if (n == abort_c) abort = 1'b1;
      if (n == retrig_c) trig_in = 1'b0;
      if (n == retrig_c + 2) trig_in = 1'b1;
      if (mutate && n == 2) cfg(1, 3, 1, 0, 4'b0000);
    end
  endtask

  task automatic gap();
    trig_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    trig_in = 1'b0;
    abort   = 1'b0;
    cfg(0, 0, 0, 0, '0);
    repeat (2) @(negedge clk);
    check("reset_a", obs, '0);
    @(negedge clk);
    check("reset_b", obs, '0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    cfg(3, 10, 4, 5, 4'b1111);
    push_burst(3, 10, 4, 5, 4'b1111, -1, 42);
    run("t1_basic", 42, 1'b1, -1, 10, 1'b1);
    gap();

    cfg(2, 10, 12, 0, 4'b1111);
    push_burst(2, 10, 12, 0, 4'b1111, -1, 24);
    run("t2_wclamp", 24, 1'b1, -1, -1, 1'b0);
    gap();

    cfg(2, 5, 0, 1, 4'b0011);
    push_burst(2, 5, 0, 1, 4'b0011, -1, 15);
    run("t2_wzero", 15, 1'b1, -1, -1, 1'b0);
    gap();

    cfg(3, 1, 1, 2, 4'b1111);
    push_burst(3, 1, 1, 2, 4'b1111, -1, 12);
    run("t2_step1", 12, 1'b1, -1, -1, 1'b0);
    gap();

    cfg(3, 10, 4, 5, 4'b0101);
    push_burst(3, 10, 4, 5, 4'b0101, -1, 40);
    run("t3_chen", 40, 1'b1, -1, -1, 1'b0);
    gap();

    cfg(3, 10, 4, 5, 4'b1111);
    push_burst(3, 10, 4, 5, 4'b1111, 14, 25);
    run("t4_abort", 25, 1'b1, 14, -1, 1'b0);
    gap();

    push_idle(10);
    run("t4_blocked", 10, 1'b1, -1, -1, 1'b0);
    abort = 1'b0;
    push_idle(6);
    run("t4_release", 6, 1'b0, -1, -1, 1'b0);
    gap();

    abort = 1'b1;
    push_idle(10);
    run("t4_same", 10, 1'b1, -1, -1, 1'b0);
    abort = 1'b0;
    gap();

`ifdef TRIG_GEN_CONT_EN
    cfg(0, 7, 3, 2, 4'b1010);
    push_burst(0, 7, 3, 2, 4'b1010, 1100, 1110);
    run("t5_cont", 1110, 1'b1, 1100, -1, 1'b0);
    abort = 1'b0;
    gap();
`else
    cfg(0, 7, 3, 2, 4'b1010);
    push_burst(0, 7, 3, 2, 4'b1010, -1, 6);
    run("t5_num0", 6, 1'b1, -1, -1, 1'b0);
    gap();
`endif

    cfg(3, 10, 4, 5, 4'b1111);
    push_burst(3, 10, 4, 5, 4'b1111, -1, 8);
    run("t6_pre", 8, 1'b1, -1, -1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("t6_async_rst", obs, '0);
    trig_in  = 1'b0;
    last_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    cfg(2, 4, 2, 0, 4'b1001);
    push_burst(2, 4, 2, 0, 4'b1001, -1, 12);
    run("t6_after", 12, 1'b1, -1, -1, 1'b0);
    gap();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
